// File: rtl/axil_rd_fifo.sv
// axil_rd_fifo: AXI-lite read path with a registered AR stage, credit-limited outstanding reads and an R FIFO.
// Ports:
//   clk, rst_n                        single clock, asynchronous active-low reset
//   s_axil_ar*/s_axil_r*              upstream AXI-lite read slave
//   m_axil_ar*/m_axil_r*              downstream AXI-lite read master
//   status_outstanding                reads accepted upstream and not yet returned upstream
//   stat_rd_count, stat_err_count     read / error-response counters (only with AXIL_RD_FIFO_STATS_EN)
module axil_rd_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_WIDTH-1:0]        s_axil_araddr,
    input  logic [2:0]                   s_axil_arprot,
    input  logic                         s_axil_arvalid,
    output logic                         s_axil_arready,
    output logic [DATA_WIDTH-1:0]        s_axil_rdata,
    output logic [1:0]                   s_axil_rresp,
    output logic                         s_axil_rvalid,
    input  logic                         s_axil_rready,
    output logic [ADDR_WIDTH-1:0]        m_axil_araddr,
    output logic [2:0]                   m_axil_arprot,
    output logic                         m_axil_arvalid,
    input  logic                         m_axil_arready,
    input  logic [DATA_WIDTH-1:0]        m_axil_rdata,
    input  logic [1:0]                   m_axil_rresp,
    input  logic                         m_axil_rvalid,
    output logic                         m_axil_rready,
`ifdef AXIL_RD_FIFO_STATS_EN
    output logic [31:0]                  stat_rd_count,
    output logic [31:0]                  stat_err_count,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   status_outstanding
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int OW = $clog2(DEPTH + 1);
    logic                  ar_vld_q, ar_vld_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [2:0]            ar_prot_q;
    logic [OW-1:0]         out_q, out_d;
    logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [DATA_WIDTH+1:0] mem_q [DEPTH];
    logic                  full, empty, ar_hs, r_hs, push;
    always_comb begin
        full           = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        empty          = wr_q == rd_q;
        // The AR stage may refill in the cycle it drains, so throughput stays at one per cycle.
        s_axil_arready = (out_q < OW'(DEPTH)) && (!ar_vld_q || m_axil_arready);
        ar_hs          = s_axil_arvalid && s_axil_arready;
        push           = m_axil_rvalid && !full;
        r_hs           = !empty && s_axil_rready;
        ar_vld_d       = ar_hs ? 1'b1 : (m_axil_arready ? 1'b0 : ar_vld_q);
        out_d          = (ar_hs && !r_hs) ? out_q + OW'(1) :
                         (!ar_hs && r_hs) ? out_q - OW'(1) : out_q;
        wr_d           = wr_q + PW'(push);
        rd_d           = rd_q + PW'(r_hs);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_vld_q <= 1'b0;
            out_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
        end else begin
            ar_vld_q <= ar_vld_d;
            out_q    <= out_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
        end
    end
    // Payload storage carries no reset; validity is tracked by ar_vld_q and the pointers.
    always_ff @(posedge clk) begin
        if (ar_hs) begin
            ar_addr_q <= s_axil_araddr;
            ar_prot_q <= s_axil_arprot;
        end
        if (push) mem_q[wr_q[AW-1:0]] <= {m_axil_rresp, m_axil_rdata};
    end
    assign m_axil_arvalid               = ar_vld_q;
    assign m_axil_araddr                = ar_addr_q;
    assign m_axil_arprot                = ar_prot_q;
    assign m_axil_rready                = !full;
    assign s_axil_rvalid                = !empty;
    assign {s_axil_rresp, s_axil_rdata} = mem_q[rd_q[AW-1:0]];
    assign status_outstanding           = out_q;
`ifdef AXIL_RD_FIFO_STATS_EN
    logic [31:0] rd_cnt_q, err_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (r_hs) begin
            rd_cnt_q  <= rd_cnt_q + 32'd1;
            err_cnt_q <= err_cnt_q + 32'(s_axil_rresp[1]);
        end
    end
    assign stat_rd_count  = rd_cnt_q;
    assign stat_err_count = err_cnt_q;
`endif
endmodule

// File: tb/tb_axil_rd_fifo.sv
// tb_axil_rd_fifo: self-checking bench for axil_rd_fifo (DEPTH=4, stats checked when AXIL_RD_FIFO_STATS_EN is defined).
module tb_axil_rd_fifo;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_axil_araddr;
    logic [2:0]  s_axil_arprot;
    logic        s_axil_arvalid, s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid, s_axil_rready;
    logic [31:0] m_axil_araddr;
    logic [2:0]  m_axil_arprot;
    logic        m_axil_arvalid, m_axil_arready;
    logic [31:0] m_axil_rdata;
    logic [1:0]  m_axil_rresp;
    logic        m_axil_rvalid, m_axil_rready;
    logic [2:0]  status_outstanding;
`ifdef AXIL_RD_FIFO_STATS_EN
    logic [31:0] stat_rd_count, stat_err_count;
`endif

    always #5 clk = ~clk;

    axil_rd_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
`ifdef AXIL_RD_FIFO_STATS_EN
        .stat_rd_count(stat_rd_count), .stat_err_count(stat_err_count),
`endif
        .status_outstanding(status_outstanding)
    );

    int checks = 0;
    int failures = 0;

    // Transaction-level reference: counts of reads in each stage plus ordered payload queues.
    int          out_m, arst_m, fifo_m, st_rd, st_err, ds_cnt, pops, acc;
    bit          seq_data, log_seen;
    logic [31:0] addr_q[$];
    logic [2:0]  prot_q[$];
    logic [33:0] ds_resp_q[$];
    logic [33:0] exp_q[$];
    logic [1:0]  resp_plan[$];
    logic [31:0] seen[$];

    typedef struct {
        bit          arv, rrdy, marr, mrv;
        logic [31:0] mdata;
        bit          e_arr, e_mav, e_srv;
        logic [31:0] e_rdata;
        int          e_out;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic clear_model();
        out_m = 0; arst_m = 0; fifo_m = 0; st_rd = 0; st_err = 0;
        addr_q.delete(); prot_q.delete(); ds_resp_q.delete(); exp_q.delete();
    endtask

    task automatic idle_inputs();
        s_axil_arvalid = 0; s_axil_araddr = '0; s_axil_arprot = '0; s_axil_rready = 0;
        m_axil_arready = 0; m_axil_rvalid = 0; m_axil_rdata = '0; m_axil_rresp = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // One clock of traffic; the bench also plays the downstream slave (answers in AR order).
    task automatic cyc(input bit arv, input bit rrdy, input bit marr, input bit mrv_en);
        bit          e_arr, e_mav, e_srv, e_mrr, ar_hs, r_hs, mar_hs, mr_hs;
        logic [31:0] a;
        logic [2:0]  p;
        logic [33:0] h;
        a = $urandom; p = 3'($urandom);
        s_axil_arvalid = arv; s_axil_araddr = a; s_axil_arprot = p; s_axil_rready = rrdy;
        m_axil_arready = marr;
        m_axil_rvalid = mrv_en && (ds_resp_q.size() > 0);
        {m_axil_rresp, m_axil_rdata} = (ds_resp_q.size() > 0) ? ds_resp_q[0] : 34'($urandom);
        #1;
        e_mav = arst_m == 1;
        e_arr = (out_m < 4) && (!e_mav || marr);
        e_srv = fifo_m > 0;
        e_mrr = fifo_m < 4;
        chk("s_arready", s_axil_arready, e_arr);
        chk("m_arvalid", m_axil_arvalid, e_mav);
        chk("s_rvalid", s_axil_rvalid, e_srv);
        chk("m_rready", m_axil_rready, e_mrr);
        chk("outstanding", status_outstanding, out_m);
        if (e_mav) begin
            chk("m_araddr", m_axil_araddr, addr_q[0]);
            chk("m_arprot", m_axil_arprot, prot_q[0]);
        end
        if (e_srv) chk("s_rdata_rresp", {s_axil_rresp, s_axil_rdata}, exp_q[0]);
`ifdef AXIL_RD_FIFO_STATS_EN
        chk("stat_rd_count", stat_rd_count, 32'(st_rd));
        chk("stat_err_count", stat_err_count, 32'(st_err));
`endif
        ar_hs = arv && e_arr;
        r_hs = e_srv && rrdy;
        mar_hs = e_mav && marr;
        mr_hs = m_axil_rvalid && e_mrr;
        if (r_hs) begin
            h = exp_q.pop_front();
            fifo_m--; pops++; st_rd++;
            if (h[33]) st_err++;
            if (log_seen) seen.push_back(h[31:0]);
        end
        if (mr_hs) begin
            exp_q.push_back(ds_resp_q.pop_front());
            fifo_m++;
        end
        if (mar_hs) begin
            void'(addr_q.pop_front());
            void'(prot_q.pop_front());
            ds_resp_q.push_back({(resp_plan.size() > 0) ? resp_plan.pop_front() : 2'($urandom),
                                 seq_data ? 32'(ds_cnt) : 32'($urandom)});
            ds_cnt++; arst_m--;
        end
        if (ar_hs) begin
            addr_q.push_back(a); prot_q.push_back(p);
            arst_m++; acc++;
        end
        out_m = out_m + int'(ar_hs) - int'(r_hs);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && out_m > 0; i++) cyc(0, 1, 1, 1);
        chk("drain_outstanding", status_outstanding, 0);
        chk("drain_rvalid", s_axil_rvalid, 0);
    endtask

    initial begin
        int p0;
        seq_data = 0; log_seen = 0; pops = 0; acc = 0; ds_cnt = 0;
        // Single read: AR at cycle 0, downstream R at cycle 3, upstream R visible at cycle 4.
        tbl[0] = '{1, 0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        0};
        tbl[1] = '{0, 0, 1, 0, 32'h0,        1, 1, 0, 32'h0,        1};
        tbl[2] = '{0, 0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        1};
        tbl[3] = '{0, 0, 0, 1, 32'hDEADBEEF, 1, 0, 0, 32'h0,        1};
        tbl[4] = '{0, 1, 0, 0, 32'h0,        1, 0, 1, 32'hDEADBEEF, 1};
        tbl[5] = '{0, 0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        0};
        do_reset();
        chk("reset_arready", s_axil_arready, 1);
        chk("reset_rvalid", s_axil_rvalid, 0);
        chk("reset_m_rready", m_axil_rready, 1);
        chk("reset_outstanding", status_outstanding, 0);
        for (int i = 0; i < 6; i++) begin
            s_axil_arvalid = tbl[i].arv; s_axil_araddr = 32'h1000; s_axil_arprot = 3'd2;
            s_axil_rready = tbl[i].rrdy; m_axil_arready = tbl[i].marr;
            m_axil_rvalid = tbl[i].mrv; m_axil_rdata = tbl[i].mdata; m_axil_rresp = 2'b00;
            #1;
            chk($sformatf("t%0d_arready", i), s_axil_arready, tbl[i].e_arr);
            chk($sformatf("t%0d_m_arvalid", i), m_axil_arvalid, tbl[i].e_mav);
            chk($sformatf("t%0d_s_rvalid", i), s_axil_rvalid, tbl[i].e_srv);
            chk($sformatf("t%0d_outstanding", i), status_outstanding, tbl[i].e_out);
            if (tbl[i].e_mav) chk($sformatf("t%0d_m_araddr", i), m_axil_araddr, 32'h1000);
            if (tbl[i].e_srv) chk($sformatf("t%0d_s_rdata", i), {s_axil_rresp, s_axil_rdata}, {2'b00, 32'hDEADBEEF});
            @(posedge clk); #1;
        end

        // Credit limit: four accepted, fifth blocked until one upstream pop.
        do_reset();
        repeat (8) cyc(1, 0, 1, 1);
        chk("credit_block_arready", s_axil_arready, 0);
        chk("credit_block_outstanding", status_outstanding, 4);
        chk("credit_block_m_rready", m_axil_rready, 0);
        cyc(1, 1, 1, 1);
        chk("credit_release_arready", s_axil_arready, 1);
        cyc(1, 0, 1, 1);
        chk("credit_fifth_outstanding", status_outstanding, 4);
        drain();

        // Simultaneous AR and R pop at outstanding=2.
        repeat (2) cyc(1, 0, 1, 1);
        repeat (3) cyc(0, 0, 1, 1);
        chk("simul_pre", status_outstanding, 2);
        cyc(1, 1, 1, 1);
        chk("simul_post", status_outstanding, 2);
        drain();

        // Ordering and pointer wrap: responses 0..19 with random upstream rready.
        ds_cnt = 0; seq_data = 1; log_seen = 1; acc = 0; seen.delete();
        for (int i = 0; i < 300 && (acc < 20 || out_m > 0); i++) cyc(acc < 20, 1'($urandom), 1, 1);
        chk("order_count", seen.size(), 20);
        for (int i = 0; i < seen.size(); i++) chk($sformatf("order_%0d", i), seen[i], i);
        seq_data = 0; log_seen = 0;
        drain();

        // Throughput: one read per cycle once the pipeline is primed.
        p0 = pops;
        repeat (30) cyc(1, 1, 1, 1);
        chk("throughput", (pops - p0) >= 26, 1);
        drain();

        // Fully random traffic.
        repeat (400) cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        drain();

        // Asynchronous reset with reads in flight.
        repeat (3) cyc(1, 0, 1, 0);
        chk("pre_reset_outstanding", status_outstanding, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_rvalid", s_axil_rvalid, 0);
        chk("async_rst_m_arvalid", m_axil_arvalid, 0);
        chk("async_rst_outstanding", status_outstanding, 0);
        chk("async_rst_arready", s_axil_arready, 1);
        idle_inputs();
        clear_model();
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        cyc(0, 0, 0, 0);

`ifdef AXIL_RD_FIFO_STATS_EN
        // Statistics: two error responses (SLVERR, DECERR) among six reads.
        do_reset();
        resp_plan = '{2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00};
        acc = 0;
        for (int i = 0; i < 20 && acc < 6; i++) cyc(1, 1, 1, 1);
        drain();
        chk("stat_rd_6", stat_rd_count, 6);
        chk("stat_err_2", stat_err_count, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
